cga_text_serializer: RTL
========================

// Module: cga_text_serializer
// PURPOSE
//  Text-mode pixel stage directly downstream of the 6845 CRTC. Once per character slot it:
//  - takes the CRTC mem_addr and row_addr;
//  - fetches the character and attribute bytes from VRAM over a req/ack port;
//  - looks up the glyph row in a synchronous font ROM;
//  - shifts out 4-bit IRGB pixels, delayed one slot with hsync, vsync and display-enable to match.
// PARAMETERS
//  CHAR_W    8   pixels per character slot (pixclk pulses per divclk period)
//  BLINK_B   4   blink counter bit used as blink phase (counter counts vsync rising edges)
// PORTS
//  clk           in   1   system clock; the only clock
//  rst_n         in   1   asynchronous active-low reset
//  divclk        in   1   char-slot enable; coincides with the first pixclk of each slot
//  pixclk        in   1   pixel enable; exactly CHAR_W pulses per divclk period
//  mem_addr      in   14  CRTC character address
//  row_addr      in   5   CRTC scanline within character row
//  display_enable in  1   CRTC active area
//  cursor        in   1   CRTC cursor (already blink-gated)
//  hsync,vsync   in   1   CRTC syncs
//  mode_blink    in   1   1: attr[7] = blink; 0: attr[7] = bright background
//  vram_addr     out  15  byte address: {mem_addr,0}=char, {mem_addr,1}=attr
//  vram_rd       out  1   read request; held until vram_ack
//  vram_ack      in   1   1-cycle pulse; vram_data valid in the same cycle
//  vram_data     in   8   read data
//  font_addr     out  11  {char,row_addr[2:0]}
//  font_data     in   8   glyph row; valid 1 clk after font_addr (bit7 = leftmost pixel)
//  pixel         out  4   IRGB pixel, registered
//  hsync_o,vsync_o,de_o out 1  syncs and display-enable delayed one slot
//  underrun      out  1   sticky: a fetch had not completed at divclk
// BEHAVIOUR
//  Reset values:
//  - outputs: all 0; vram_rd=0; underrun=0.
//  - internal: FSM=IDLE; shifter/attr/blink counter = 0.
//  Fetch FSM: IDLE -> RD_CHAR -> RD_ATTR -> FONT -> DONE.
//  - At divclk: latch mem_addr, row_addr, display_enable, cursor, hsync, vsync into stage S1.
//    Go to RD_CHAR from any state.
//  - RD_CHAR: vram_addr={S1.addr,0}, vram_rd=1. On ack: char<=vram_data, go to RD_ATTR.
//  - RD_ATTR: vram_addr={S1.addr,1}, vram_rd=1. On ack: attr<=vram_data, go to FONT.
//  - vram_rd drops the cycle after ack; the request is never withdrawn before ack except by reset.
//  - FONT: drive font_addr for 1 clk. Next clk: pattern<=font_data, go to DONE.
//    If S1.row_addr[4:3]!=0, pattern<=8'h00.
//  - DONE: hold until divclk.
//  - divclk in RD_CHAR/RD_ATTR/FONT (fetch incomplete):
//    - set underrun;
//    - stage S2 gets pattern=0, attr=0;
//    - vram_rd drops for one clk, then the FSM restarts RD_CHAR with the new address;
//    - an ack arriving in the drop cycle is ignored.
//  Load at divclk: transfer the completed S1 result to S2, same cycle as the new S1 capture.
//  - shifter <= S2.de ? (S2.cursor ? 8'hFF : pattern) : 8'h00;
//  - hsync_o/vsync_o/de_o <= S2 values.
//  Pixel, per pixclk (registered):
//  - bit = shifter[7], then shift left with 0 in.
//  - fg = attr[3:0].
//  - bg = mode_blink ? {0,attr[6:4]} : attr[7:4].
//  - if mode_blink & attr[7] & blink_cnt[BLINK_B] & !cursor_bit: fg=bg.
//  - pixel <= de ? (bit ? fg : bg) : 0.
//  Latency: slot captured at divclk N appears on pixel from divclk N+1 (+1 clk register), CHAR_W pixels.
//  Blink counter:
//  - 5-bit; increments on each vsync rising edge (edge-detect reg, reset 0).
//  - wraps 31->0.
//  divclk and pixclk in the same cycle: load has priority; the first pixel comes from the new shifter.
//  Reset mid-fetch: vram_rd deasserts immediately (async); no further requests until the next divclk.
// TESTING
//  1. VRAM char 0x41 attr 0x1E, glyph row 8'b0011_1100, ack after 2 clk
//     -> next slot pixels 1,1,E,E,E,E,1,1; de_o=1.
//  2. cursor=1, de=1 -> all 8 pixels = fg (attr[3:0]); underrun stays 0.
//  3. ack withheld past divclk -> underrun=1, that slot outputs bg of attr 0 (=0);
//     next fetch uses new mem_addr; vram_rd low exactly 1 clk.
//  4. mode_blink=1, attr=0x8F, 16 vsync rising edges -> fg pixels become 0 while blink_cnt[4]=1;
//     mode_blink=0 -> bg=8.
//  5. row_addr=9 -> pattern 0, all pixels = bg; display_enable=0 -> pixel=0 and de_o=0 one slot later.
//  6. rst_n low during RD_ATTR -> vram_rd=0 and pixel=0 asynchronously;
//     after release, idle until divclk, then normal fetch.

Source files
------------

// File: rtl/cga_text_serializer.sv
// Text-mode pixel stage behind a 6845 CRTC: per character slot it fetches char/attr from VRAM,
// looks up the glyph row in a synchronous font ROM and serialises IRGB pixels one slot later.
module cga_text_serializer #(
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned BLINK_B = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        divclk,
  input  logic        pixclk,
  input  logic [13:0] mem_addr,
  input  logic [4:0]  row_addr,
  input  logic        display_enable,
  input  logic        cursor,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        mode_blink,
  output logic [14:0] vram_addr,
  output logic        vram_rd,
  input  logic        vram_ack,
  input  logic [7:0]  vram_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  pixel,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        underrun
);

  localparam int unsigned AW = 14;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = 4;
  localparam int unsigned BW = 5;

  typedef enum logic [2:0] {IDLE, RD_CHAR, RD_ATTR, FONT, FONT_LAT, DONE} state_t;

  state_t            r_state, w_state_n;
  logic              w_abort, w_ack, w_done;

  logic [AW-1:0]     r_s1_addr;
  logic [RW-1:0]     r_s1_row;
  logic              r_s1_de, r_s1_cur, r_s1_hs, r_s1_vs;
  logic [DW-1:0]     r_attr_f, r_pat_f;
  logic              r_vram_rd, r_underrun;
  logic [14:0]       r_vram_addr;
  logic [10:0]       r_font_addr;

  logic [CHAR_W-1:0] r_shift;
  logic [DW-1:0]     r_attr;
  logic              r_cur, r_de, r_hs, r_vs, r_vs_d;
  logic [PW-1:0]     r_pixel;
  logic [BW-1:0]     r_blink;

  logic [AW-1:0]     w_s1_addr_n;
  logic [DW-1:0]     w_ld_pat, w_ld_attr, w_src_attr;
  logic [CHAR_W-1:0] w_ld_shift, w_src_shift;
  logic              w_src_de, w_src_cur;
  logic [PW-1:0]     w_fg, w_bg, w_fg_eff;

  assign w_ack  = vram_ack & r_vram_rd;
  assign w_done = (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  // A new slot always restarts the fetch; leaving a fetch early is an underrun
  always_comb begin
    w_state_n = r_state;
    w_abort   = 1'b0;
    if (divclk) begin
      w_state_n = RD_CHAR;
      w_abort   = (r_state inside {RD_CHAR, RD_ATTR, FONT, FONT_LAT});
    end else begin
      case (r_state)
        RD_CHAR:  if (w_ack) w_state_n = RD_ATTR;
        RD_ATTR:  if (w_ack) w_state_n = FONT;
        FONT:     w_state_n = FONT_LAT;
        FONT_LAT: w_state_n = DONE;
        default:  w_state_n = r_state;
      endcase
    end
  end

  assign w_s1_addr_n = divclk ? mem_addr : r_s1_addr;

  // Stage S1 capture, VRAM request port and fetch results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_addr   <= '0;
      r_s1_row    <= '0;
      r_s1_de     <= 1'b0;
      r_s1_cur    <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_attr_f    <= '0;
      r_pat_f     <= '0;
      r_vram_rd   <= 1'b0;
      r_vram_addr <= '0;
      r_font_addr <= '0;
      r_underrun  <= 1'b0;
    end else begin
      if (divclk) begin
        r_s1_addr <= mem_addr;
        r_s1_row  <= row_addr;
        r_s1_de   <= display_enable;
        r_s1_cur  <= cursor;
        r_s1_hs   <= hsync;
        r_s1_vs   <= vsync;
      end
      if (w_abort) r_underrun <= 1'b1;
      // request drops for one clk after every ack and after every slot boundary
      r_vram_rd   <= !divclk && !w_ack && (w_state_n == RD_CHAR || w_state_n == RD_ATTR);
      r_vram_addr <= {w_s1_addr_n, (w_state_n == RD_ATTR)};
      if (!divclk) begin
        case (r_state)
          RD_CHAR:  if (w_ack) r_font_addr <= {vram_data, r_s1_row[2:0]};
          RD_ATTR:  if (w_ack) r_attr_f <= vram_data;
          FONT_LAT: r_pat_f <= (|r_s1_row[4:3]) ? '0 : font_data;
          default:  ;
        endcase
      end
    end
  end

  // Values entering S2 at the slot boundary; incomplete fetches blank to attr 0
  always_comb begin
    w_ld_pat    = w_done ? r_pat_f  : '0;
    w_ld_attr   = w_done ? r_attr_f : '0;
    w_ld_shift  = r_s1_de ? (r_s1_cur ? '1 : CHAR_W'(w_ld_pat)) : '0;
    w_src_shift = divclk ? w_ld_shift : r_shift;
    w_src_attr  = divclk ? w_ld_attr  : r_attr;
    w_src_de    = divclk ? r_s1_de    : r_de;
    w_src_cur   = divclk ? r_s1_cur   : r_cur;
    w_fg        = w_src_attr[3:0];
    w_bg        = mode_blink ? {1'b0, w_src_attr[6:4]} : w_src_attr[7:4];
    w_fg_eff    = (mode_blink && w_src_attr[7] && r_blink[BLINK_B] && !w_src_cur) ? w_bg : w_fg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_attr  <= '0;
      r_cur   <= 1'b0;
      r_de    <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_pixel <= '0;
      r_vs_d  <= 1'b0;
      r_blink <= '0;
    end else begin
      r_vs_d <= vsync;
      if (vsync && !r_vs_d) r_blink <= r_blink + BW'(1);
      if (divclk) begin
        r_attr <= w_ld_attr;
        r_cur  <= r_s1_cur;
        r_de   <= r_s1_de;
        r_hs   <= r_s1_hs;
        r_vs   <= r_s1_vs;
      end
      if (pixclk) begin
        r_shift <= {w_src_shift[CHAR_W-2:0], 1'b0};
        r_pixel <= w_src_de ? (w_src_shift[CHAR_W-1] ? w_fg_eff : w_bg) : '0;
      end else if (divclk) begin
        r_shift <= w_ld_shift;
      end
    end
  end

  assign vram_rd   = r_vram_rd;
  assign vram_addr = r_vram_addr;
  assign font_addr = r_font_addr;
  assign underrun  = r_underrun;
  assign pixel     = r_pixel;
  assign hsync_o   = r_hs;
  assign vsync_o   = r_vs;
  assign de_o      = r_de;

endmodule
